// File: rtl/sap_ctrl_seq.sv
// SAP-1 controller-sequencer: six-state one-hot ring (T1..T6) plus HALT flag,
// decoded with the IR opcode into the bus control word. Optional JMP via CTRL_JMP_EN.
module sap_ctrl_seq #(
  parameter int             OPW    = 4,
  parameter logic [OPW-1:0] OP_LDA = 4'b0000,
  parameter logic [OPW-1:0] OP_ADD = 4'b0001,
  parameter logic [OPW-1:0] OP_SUB = 4'b0010,
  parameter logic [OPW-1:0] OP_JMP = 4'b0011,
  parameter logic [OPW-1:0] OP_OUT = 4'b1110,
  parameter logic [OPW-1:0] OP_HLT = 4'b1111
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [OPW-1:0] ir_op,
  output logic           Cp,
  output logic           Ep,
  output logic           Lm,
  output logic           CE,
  output logic           Li,
  output logic           Ei,
  output logic           La,
  output logic           Ea,
  output logic           Su,
  output logic           Eu,
  output logic           Lb,
  output logic           Lo,
`ifdef CTRL_JMP_EN
  output logic           Lp,
`endif
  output logic           halted,
  output logic [5:0]     t_state
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e t_state_q, t_state_d;
  logic     halted_q, halted_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      t_state_q <= T1;
      halted_q  <= 1'b0;
    end else begin
      t_state_q <= t_state_d;
      halted_q  <= halted_d;
    end
  end

  // HLT is recognised at the end of T4 and freezes the ring there until clr.
  always_comb begin
    t_state_d = t_state_q;
    halted_d  = halted_q;
    if (!halted_q) begin
      case (t_state_q)
        T1: t_state_d = T2;
        T2: t_state_d = T3;
        T3: t_state_d = T4;
        T4: begin
          if (ir_op == OP_HLT) halted_d = 1'b1;
          else                 t_state_d = T5;
        end
        T5: t_state_d = T6;
        T6: t_state_d = T1;
        default: t_state_d = T1;
      endcase
    end
  end

  always_comb begin
    Cp = 1'b0; Ep = 1'b0; Lm = 1'b0; CE = 1'b0; Li = 1'b0; Ei = 1'b0;
    La = 1'b0; Ea = 1'b0; Su = 1'b0; Eu = 1'b0; Lb = 1'b0; Lo = 1'b0;
`ifdef CTRL_JMP_EN
    Lp = 1'b0;
`endif
    if (!clr && !halted_q) begin
      case (t_state_q)
        T1: begin Ep = 1'b1; Lm = 1'b1; end
        T2: Cp = 1'b1;
        T3: begin CE = 1'b1; Li = 1'b1; end
        default: begin
          // Execute phase: ir_op only matters from T4 on, after IR has loaded.
          case (ir_op)
            OP_LDA: begin
              if (t_state_q == T4) begin Ei = 1'b1; Lm = 1'b1; end
              if (t_state_q == T5) begin CE = 1'b1; La = 1'b1; end
            end
            OP_ADD, OP_SUB: begin
              if (t_state_q == T4) begin Ei = 1'b1; Lm = 1'b1; end
              if (t_state_q == T5) begin CE = 1'b1; Lb = 1'b1; end
              if (t_state_q == T6) begin
                Eu = 1'b1;
                La = 1'b1;
                Su = (ir_op == OP_SUB);
              end
            end
            OP_OUT: begin
              if (t_state_q == T4) begin Ea = 1'b1; Lo = 1'b1; end
            end
`ifdef CTRL_JMP_EN
            OP_JMP: begin
              if (t_state_q == T4) begin Ei = 1'b1; Lp = 1'b1; end
            end
`endif
            default: ;
          endcase
        end
      endcase
    end
  end

  assign t_state = t_state_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Table-driven bench for sap_ctrl_seq: per-cycle vectors of {clr, ir_op} with expected
// ring state, control word and halt flag, plus hand-written HALT hold/release sequence.
module tb_sap_ctrl_seq;

  localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
  localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
  localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;
  localparam logic [5:0]  S1 = 6'b000001, S2 = 6'b000010, S3 = 6'b000100;
  localparam logic [5:0]  S4 = 6'b001000, S5 = 6'b010000, S6 = 6'b100000;
`ifdef CTRL_JMP_EN
  localparam logic [11:0] JMP_T4 = EI;
  localparam logic        JMP_LP = 1'b1;
`else
  localparam logic [11:0] JMP_T4 = 12'h000;
  localparam logic        JMP_LP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] ir_op;
  logic       Cp, Ep, Lm, CE_o, Li, Ei, La, Ea, Su, Eu, Lb, Lo, halted;
  logic [5:0] t_state;
  logic       lp_act;
`ifdef CTRL_JMP_EN
  logic       Lp;
  assign lp_act = Lp;
`else
  assign lp_act = 1'b0;
`endif
  logic [11:0] ctrl;
  assign ctrl = {Cp, Ep, Lm, CE_o, Li, Ei, La, Ea, Su, Eu, Lb, Lo};

  always #5 clk = ~clk;

  sap_ctrl_seq dut (
    .clk(clk), .clr(clr), .ir_op(ir_op),
    .Cp(Cp), .Ep(Ep), .Lm(Lm), .CE(CE_o), .Li(Li), .Ei(Ei),
    .La(La), .Ea(Ea), .Su(Su), .Eu(Eu), .Lb(Lb), .Lo(Lo),
`ifdef CTRL_JMP_EN
    .Lp(Lp),
`endif
    .halted(halted), .t_state(t_state)
  );

  typedef struct {
    logic        clr;
    logic [3:0]  op;
    logic [5:0]  ts;
    logic [11:0] ctrl;
    logic        lp;
    logic        hl;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input logic c, input logic [3:0] op, input logic [5:0] ts,
                     input logic [11:0] cw, input logic lp, input logic hl);
    vec_t v;
    v.clr = c; v.op = op; v.ts = ts; v.ctrl = cw; v.lp = lp; v.hl = hl;
    vq.push_back(v);
  endtask

  // Fetch cycles use a varying opcode to show ir_op is ignored in T1..T3.
  task automatic fetch(input logic [3:0] op);
    add(1'b0, op,          S1, EP | LM, 1'b0, 1'b0);
    add(1'b0, op ^ 4'hA,   S2, CP,      1'b0, 1'b0);
    add(1'b0, op ^ 4'h5,   S3, CE | LI, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input int idx, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec%0d got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    clr   = v.clr;
    ir_op = v.op;
    @(negedge clk);
    chk("t_state", idx, {6'd0, t_state}, {6'd0, v.ts});
    chk("ctrl",    idx, ctrl, v.ctrl);
    chk("halted",  idx, {11'd0, halted}, {11'd0, v.hl});
`ifdef CTRL_JMP_EN
    chk("Lp",      idx, {11'd0, lp_act}, {11'd0, v.lp});
`endif
    tests++;
    if ($countones({Ep, CE_o, Ei, Ea, Eu}) > 1) begin
      fails++;
      $display("FAIL bus_excl vec%0d got %b want at most one driver", idx, {Ep, CE_o, Ei, Ea, Eu});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    clr = 1'b1;
    ir_op = 4'h0;
    @(posedge clk);
    #1;

    add(1'b1, 4'h0, S1, 12'h000, 1'b0, 1'b0);
    // LDA
    fetch(4'hF);
    add(1'b0, 4'h0, S4, EI | LM, 1'b0, 1'b0);
    add(1'b0, 4'h0, S5, CE | LA, 1'b0, 1'b0);
    add(1'b0, 4'h0, S6, 12'h000, 1'b0, 1'b0);
    // ADD
    fetch(4'h2);
    add(1'b0, 4'h1, S4, EI | LM, 1'b0, 1'b0);
    add(1'b0, 4'h1, S5, CE | LB, 1'b0, 1'b0);
    add(1'b0, 4'h1, S6, EU | LA, 1'b0, 1'b0);
    // SUB
    fetch(4'h1);
    add(1'b0, 4'h2, S4, EI | LM, 1'b0, 1'b0);
    add(1'b0, 4'h2, S5, CE | LB, 1'b0, 1'b0);
    add(1'b0, 4'h2, S6, SU | EU | LA, 1'b0, 1'b0);
    // OUT
    fetch(4'h0);
    add(1'b0, 4'hE, S4, EA | LO, 1'b0, 1'b0);
    add(1'b0, 4'hE, S5, 12'h000, 1'b0, 1'b0);
    add(1'b0, 4'hE, S6, 12'h000, 1'b0, 1'b0);
    // undefined opcode acts as NOP
    fetch(4'h3);
    add(1'b0, 4'h5, S4, 12'h000, 1'b0, 1'b0);
    add(1'b0, 4'h5, S5, 12'h000, 1'b0, 1'b0);
    add(1'b0, 4'h5, S6, 12'h000, 1'b0, 1'b0);
    // JMP
    fetch(4'h9);
    add(1'b0, 4'h3, S4, JMP_T4,  JMP_LP, 1'b0);
    add(1'b0, 4'h3, S5, 12'h000, 1'b0, 1'b0);
    add(1'b0, 4'h3, S6, 12'h000, 1'b0, 1'b0);
    // ADD aborted by clr in T5
    fetch(4'h7);
    add(1'b0, 4'h1, S4, EI | LM, 1'b0, 1'b0);
    add(1'b1, 4'h1, S5, 12'h000, 1'b0, 1'b0);
    // restart, then HLT reaching T4
    fetch(4'hF);
    add(1'b0, 4'hF, S4, 12'h000, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) apply(i, vq[i]);

    // HALT holds T4 with all controls low regardless of ir_op
    for (int i = 0; i < 22; i++) begin
      v.clr = 1'b0; v.op = 4'(i); v.ts = S4; v.ctrl = 12'h000; v.lp = 1'b0; v.hl = 1'b1;
      apply(100 + i, v);
    end
    v.clr = 1'b1; v.op = 4'h0; v.ts = S4; v.ctrl = 12'h000; v.lp = 1'b0; v.hl = 1'b1;
    apply(200, v);
    v.clr = 1'b0; v.op = 4'h0; v.ts = S1; v.ctrl = EP | LM; v.lp = 1'b0; v.hl = 1'b0;
    apply(201, v);
    v.clr = 1'b0; v.op = 4'h0; v.ts = S2; v.ctrl = CP; v.lp = 1'b0; v.hl = 1'b0;
    apply(202, v);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
